// File: rtl/prach_tdm_deframer_if.sv
// Output sample stream of the PRACH TDM deframer.
// A valid/ready handshake carries one sample and its channel tag per transfer.
//   m_valid  master->slave  sample available
//   m_ready  slave->master  downstream accepts the sample
//   m_dr     master->slave  sample real, signed
//   m_di     master->slave  sample imag, signed
//   m_chn    master->slave  channel the sample belongs to
interface prach_tdm_deframer_if;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_dr;
   logic [15:0] m_di;
   logic [7:0]  m_chn;

   modport master (output m_valid, m_dr, m_di, m_chn, input m_ready);
   modport slave  (input m_valid, m_dr, m_di, m_chn, output m_ready);
endinterface

// File: rtl/prach_tdm_deframer.sv
// PRACH TDM deframer: receive end of the 8-slot channel stream from the mixer.
// Input samples are registered once. The registered slot index is then checked
// against a free-running expected-slot counter. Slot alignment is tracked by a
// HUNT / CHECK / LOCKED state machine. While LOCKED, samples of enabled
// channels go into a first-word-fall-through FIFO, which feeds the output
// handshake.
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   din_dr, din_di     input sample (real/imag, signed, passed unmodified)
//   din_chn            slot index of the current input sample
//   sync_in            frame marker, legal only in slot 0
//   ctrl_ch_en         per-channel capture enable, bit index = channel
//   ctrl_clr_err       pulse: clear the sticky status flags
//   m                  output sample stream (master side)
//   stat_locked        alignment state is LOCKED
//   stat_ovf           sticky: a sample was dropped because the FIFO was full
//   stat_sync_err      sticky: alignment was lost while LOCKED
//   stat_fill          FIFO occupancy
module prach_tdm_deframer #(
   parameter int NumCh     = 8,
   parameter int FifoDepth = 16,
   parameter int LockCnt   = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [15:0]                 din_dr,
   input  logic [15:0]                 din_di,
   input  logic [7:0]                  din_chn,
   input  logic                        sync_in,
   input  logic [7:0]                  ctrl_ch_en,
   input  logic                        ctrl_clr_err,
   prach_tdm_deframer_if.master        m,
   output logic                        stat_locked,
   output logic                        stat_ovf,
   output logic                        stat_sync_err,
   output logic [$clog2(FifoDepth):0]  stat_fill
);

   localparam int AW  = $clog2(FifoDepth);
   localparam int FW  = AW + 1;
   localparam int FcW = (LockCnt > 1) ? $clog2(LockCnt) : 1;

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // ---------------------------------------------------------------------
   // Stage R: input register
   // ---------------------------------------------------------------------
   logic [15:0] r_dr;
   logic [15:0] r_di;
   logic [7:0]  r_chn;
   logic        r_sync;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its sources.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dr   <= '0;
         r_di   <= '0;
         r_chn  <= '0;
         r_sync <= 1'b0;
      end else begin
         r_dr   <= din_dr;
         r_di   <= din_di;
         r_chn  <= din_chn;
         r_sync <= sync_in;
      end
   end

   // ---------------------------------------------------------------------
   // Alignment tracking
   // ---------------------------------------------------------------------
   logic [1:0]     state, state_nxt;
   logic [2:0]     exp_slot, exp_nxt, exp_inc;
   logic [FcW-1:0] frame_cnt, frame_cnt_nxt;
   logic           mismatch;
   logic           sync0;
   logic           lock_entry;
   logic           sync_lost;

   assign exp_inc  = (exp_slot == 3'(NumCh - 1)) ? 3'd0 : exp_slot + 3'd1;
   assign mismatch = (r_chn != {5'd0, exp_slot}) || (r_sync && (r_chn != 8'd0));
   assign sync0    = r_sync && (r_chn == 8'd0);

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      exp_nxt       = exp_inc;
      frame_cnt_nxt = frame_cnt;
      lock_entry    = 1'b0;
      sync_lost     = 1'b0;
      case (state)
         ST_HUNT: begin
            if (sync0) begin
               state_nxt     = ST_CHECK;
               exp_nxt       = 3'd1;
               frame_cnt_nxt = '0;
            end
         end
         ST_CHECK: begin
            if (mismatch) begin
               state_nxt = ST_HUNT;
            end else if (exp_slot == 3'd0) begin
               // A correctly placed slot 0 completes one error-free frame.
               if (frame_cnt == FcW'(LockCnt - 1)) begin
                  state_nxt  = ST_LOCKED;
                  lock_entry = 1'b1;
               end else begin
                  frame_cnt_nxt = frame_cnt + FcW'(1);
               end
            end
         end
         ST_LOCKED: begin
            if (mismatch) begin
               state_nxt = ST_HUNT;
               sync_lost = 1'b1;
            end
         end
         default: state_nxt = ST_HUNT;
      endcase
      // A misplaced frame start that is itself a valid slot-0 sync restarts
      // the check immediately instead of going through HUNT.
      if ((state != ST_HUNT) && mismatch && sync0) begin
         state_nxt     = ST_CHECK;
         exp_nxt       = 3'd1;
         frame_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_HUNT;
         exp_slot  <= '0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         exp_slot  <= exp_nxt;
         frame_cnt <= frame_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Capture and FIFO
   // ---------------------------------------------------------------------
   logic          wr_req;
   logic          push;
   logic          pop;
   logic          drop;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [FW-1:0] fill;
   logic [39:0]   mem [FifoDepth];
   logic [39:0]   head;

   // When LOCKED with no mismatch, r_chn equals exp_slot (< 8), so the low
   // three bits select the enable exactly.
   assign wr_req = (((state == ST_LOCKED) && !mismatch) || lock_entry)
                   && ctrl_ch_en[r_chn[2:0]];
   assign pop    = m.m_valid && m.m_ready;
   assign push   = wr_req && ((fill < FW'(FifoDepth)) || pop);
   assign drop   = wr_req && !push;

   // NOTE: the sample storage has no reset; only pointers and occupancy
   // define what is valid, and m_* are forced to 0 while nothing is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {r_chn, r_dr, r_di};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            fill <= fill + FW'(1);
         end else if (pop && !push) begin
            fill <= fill - FW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Status flags: a new error in the clear cycle keeps the flag set
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ovf      <= 1'b0;
         stat_sync_err <= 1'b0;
      end else begin
         if (drop) begin
            stat_ovf <= 1'b1;
         end else if (ctrl_clr_err) begin
            stat_ovf <= 1'b0;
         end
         if (sync_lost) begin
            stat_sync_err <= 1'b1;
         end else if (ctrl_clr_err) begin
            stat_sync_err <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: head of the FIFO falls through combinationally
   // ---------------------------------------------------------------------
   assign head      = mem[rd_ptr];
   assign m.m_valid = (fill != '0);
   assign m.m_chn   = m.m_valid ? head[39:32] : 8'd0;
   assign m.m_dr    = m.m_valid ? head[31:16] : 16'd0;
   assign m.m_di    = m.m_valid ? head[15:0]  : 16'd0;

   assign stat_locked = (state == ST_LOCKED);
   assign stat_fill   = fill;

endmodule

// File: tb/tb_prach_tdm_deframer.sv
// Self-checking bench for prach_tdm_deframer.
// A reference model, kept as an anchor flag plus a run length since the
// anchoring slot-0 sync, decides lock and capture. The model queue gives
// the expected FIFO contents. A compare process checks every cycle against
// the model. Directed scenarios add hand-computed literal expectations.
module tb_prach_tdm_deframer;

   localparam int NumCh     = 8;
   localparam int FifoDepth = 16;
   localparam int LockCnt   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din_dr, din_di;
   logic [7:0]  din_chn;
   logic        sync_in;
   logic [7:0]  ctrl_ch_en;
   logic        ctrl_clr_err;
   logic        stat_locked, stat_ovf, stat_sync_err;
   logic [4:0]  stat_fill;

   prach_tdm_deframer_if m_if ();

   prach_tdm_deframer #(
      .NumCh     (NumCh),
      .FifoDepth (FifoDepth),
      .LockCnt   (LockCnt)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din_dr        (din_dr),
      .din_di        (din_di),
      .din_chn       (din_chn),
      .sync_in       (sync_in),
      .ctrl_ch_en    (ctrl_ch_en),
      .ctrl_clr_err  (ctrl_clr_err),
      .m             (m_if.master),
      .stat_locked   (stat_locked),
      .stat_ovf      (stat_ovf),
      .stat_sync_err (stat_sync_err),
      .stat_fill     (stat_fill)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [7:0]  chn;
      logic [15:0] dr;
      logic [15:0] di;
   } sample_t;

   sample_t     q[$];
   bit          anchored   = 1'b0;
   int          run        = 0;
   bit          mdl_locked = 1'b0;
   bit          mdl_ovf    = 1'b0;
   bit          mdl_serr   = 1'b0;
   logic [15:0] h_dr = '0, h_di = '0;
   logic [7:0]  h_chn = '0;
   logic        h_sync = 1'b0;
   bit          mp, mmatch, mwas_locked, mwr, mdrop;
   bit          cmp_on = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         anchored   = 1'b0;
         run        = 0;
         mdl_locked = 1'b0;
         mdl_ovf    = 1'b0;
         mdl_serr   = 1'b0;
         h_dr = '0; h_di = '0; h_chn = '0; h_sync = 1'b0;
      end else begin
         mp          = (q.size() != 0) && m_if.m_ready;
         mwas_locked = mdl_locked;
         // Slot held in the input register must be the successor of the
         // previous one counted from the anchoring sync.
         mmatch = anchored && (h_chn == 8'((run + 1) % NumCh)) && !(h_sync && h_chn != 8'd0);
         if (mmatch) run++;
         else begin
            anchored = h_sync && (h_chn == 8'd0);
            run      = 0;
         end
         mdl_locked = anchored && (run >= LockCnt * NumCh);
         mwr        = mdl_locked && ctrl_ch_en[h_chn];
         mdrop      = mwr && (q.size() >= FifoDepth) && !mp;
         if (mp) void'(q.pop_front());
         if (mwr && !mdrop) q.push_back('{h_chn, h_dr, h_di});
         if (mdrop) mdl_ovf = 1'b1;
         else if (ctrl_clr_err) mdl_ovf = 1'b0;
         if (mwas_locked && !mmatch) mdl_serr = 1'b1;
         else if (ctrl_clr_err) mdl_serr = 1'b0;
         h_dr = din_dr; h_di = din_di; h_chn = din_chn; h_sync = sync_in;
      end
   end

   always @(negedge clk) begin
      if (cmp_on && rst_n === 1'b1) begin
         check("m_valid", {31'd0, m_if.m_valid}, {31'd0, q.size() != 0});
         if (q.size() != 0) begin
            check("m_chn", {24'd0, m_if.m_chn}, {24'd0, q[0].chn});
            check("m_dr",  {16'd0, m_if.m_dr},  {16'd0, q[0].dr});
            check("m_di",  {16'd0, m_if.m_di},  {16'd0, q[0].di});
         end
         check("stat_fill",     {27'd0, stat_fill},     32'(q.size()));
         check("stat_locked",   {31'd0, stat_locked},   {31'd0, mdl_locked});
         check("stat_ovf",      {31'd0, stat_ovf},      {31'd0, mdl_ovf});
         check("stat_sync_err", {31'd0, stat_sync_err}, {31'd0, mdl_serr});
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   int chn_ptr = 0;
   int gcyc    = 0;

   function automatic logic [15:0] dr_of(input int g);
      return 16'(g * 7 + 256);
   endfunction

   function automatic logic [15:0] di_of(input int g);
      return 16'(40960 - g * 3);
   endfunction

   // Drive one TDM slot for one clock; returns 1 time unit after the edge.
   task automatic step();
      din_chn = 8'(chn_ptr);
      sync_in = (chn_ptr == 0);
      din_dr  = dr_of(gcyc);
      din_di  = di_of(gcyc);
      @(posedge clk);
      #1;
      gcyc++;
      chn_ptr = (chn_ptr + 1) % NumCh;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int g0, ga, waited, pops;

   initial begin
      rst_n        = 1'b0;
      din_dr       = '0;
      din_di       = '0;
      din_chn      = '0;
      sync_in      = 1'b0;
      ctrl_ch_en   = 8'h05;
      ctrl_clr_err = 1'b0;
      m_if.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check("rst m_valid", {31'd0, m_if.m_valid}, 32'd0);
      check("rst m_dr",    {16'd0, m_if.m_dr},    32'd0);
      check("rst fill",    {27'd0, stat_fill},    32'd0);
      check("rst locked",  {31'd0, stat_locked},  32'd0);
      check("rst flags",   {30'd0, stat_ovf, stat_sync_err}, 32'd0);

      // 1: clean stream, sync in every slot 0 from cycle 0, en = 0x05
      rst_n  = 1'b1;
      cmp_on = 1'b1;
      chn_ptr = 0;
      g0 = gcyc;
      repeat (17) step();                       // now in cycle 17
      check("s1 locked c17", {31'd0, stat_locked}, 32'd0);
      check("s1 no out c17", {31'd0, m_if.m_valid}, 32'd0);
      step();                                   // cycle 18
      check("s1 locked c18", {31'd0, stat_locked}, 32'd1);
      check("s1 first chn",  {24'd0, m_if.m_chn}, 32'd0);
      check("s1 first dr",   {16'd0, m_if.m_dr},  {16'd0, dr_of(g0 + 16)});
      step();                                   // cycle 19: slot 1 disabled
      check("s1 gap c19", {31'd0, m_if.m_valid}, 32'd0);
      step();                                   // cycle 20: slot 2 of cycle 18
      check("s1 chn2", {24'd0, m_if.m_chn}, 32'd2);
      check("s1 chn2 di", {16'd0, m_if.m_di}, {16'd0, di_of(g0 + 18)});
      repeat (20) step();

      // 2: slot jump 3 -> 5 while LOCKED
      waited = 0;
      while (chn_ptr != 4 && waited < 16) begin step(); waited++; end
      chn_ptr = 5;
      step();                                   // slot 5 driven
      step();
      check("s2 unlocked", {31'd0, stat_locked},   32'd0);
      check("s2 sync_err", {31'd0, stat_sync_err}, 32'd1);
      waited = 0;
      while (!stat_locked && waited < 40) begin step(); waited++; end
      check("s2 relock delay", 32'(waited), 32'd19);

      // 3: overflow with en = 0xFF and m_ready = 0
      ctrl_ch_en = 8'h00;
      repeat (6) step();
      m_if.m_ready = 1'b0;
      repeat (2) step();
      check("s3 empty", {27'd0, stat_fill}, 32'd0);
      ctrl_ch_en = 8'hFF;
      ga = gcyc;
      repeat (15) step();
      check("s3 fill15", {27'd0, stat_fill}, 32'd15);
      step();
      check("s3 fill16", {27'd0, stat_fill}, 32'd16);
      check("s3 no ovf yet", {31'd0, stat_ovf}, 32'd0);
      check("s3 head dr", {16'd0, m_if.m_dr}, {16'd0, dr_of(ga - 1)});
      step();
      check("s3 ovf", {31'd0, stat_ovf}, 32'd1);
      check("s3 fill held", {27'd0, stat_fill}, 32'd16);

      // 5a: clear pulse coincident with a new overflow
      ctrl_clr_err = 1'b1;
      step();
      ctrl_clr_err = 1'b0;
      check("s5 ovf wins", {31'd0, stat_ovf}, 32'd1);
      check("s5 serr cleared", {31'd0, stat_sync_err}, 32'd0);

      // 4 + 5b: full FIFO, m_ready = 1, continuous input; clear pulse alone
      m_if.m_ready = 1'b1;
      ctrl_clr_err = 1'b1;
      step();
      ctrl_clr_err = 1'b0;
      check("s5 flags cleared", {30'd0, stat_ovf, stat_sync_err}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("s4 fill16", {27'd0, stat_fill}, 32'd16);
      end
      check("s4 no ovf", {31'd0, stat_ovf}, 32'd0);

      // Drain: exactly 16 samples leave
      ctrl_ch_en = 8'h00;
      pops = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_if.m_valid && m_if.m_ready) pops++;
         step();
      end
      check("s3 drained count", 32'(pops), 32'd16);

      // 6: asynchronous reset with fill = 5
      ctrl_ch_en   = 8'hFF;
      m_if.m_ready = 1'b0;
      repeat (5) step();
      check("s6 fill5", {27'd0, stat_fill}, 32'd5);
      rst_n = 1'b0;
      #1;
      check("s6 m_valid", {31'd0, m_if.m_valid}, 32'd0);
      check("s6 fill0",   {27'd0, stat_fill},    32'd0);
      check("s6 locked",  {31'd0, stat_locked},  32'd0);
      repeat (2) @(posedge clk);
      #1;
      ctrl_ch_en   = 8'h05;
      m_if.m_ready = 1'b1;
      chn_ptr      = 0;
      rst_n        = 1'b1;
      g0 = gcyc;
      repeat (17) step();
      check("s6 locked c17", {31'd0, stat_locked}, 32'd0);
      step();
      check("s6 locked c18", {31'd0, stat_locked}, 32'd1);
      check("s6 first dr",   {16'd0, m_if.m_dr},  {16'd0, dr_of(g0 + 16)});
      repeat (10) step();

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
